// File: rtl/instr_mem_loader_if.sv
// Bus bundle between the processor side / switch panel and the instruction
// memory loader. The loader sits on the slave modport.
interface instr_mem_loader_if #(
    parameter int PTR_W = 5
);
    logic [7:0]       Read_Address;
    logic [7:0]       Instruction;
    logic             LOAD_MODE;
    logic [7:0]       LOAD_DATA;
    logic             LOAD_BTN;
    logic             CPU_HOLD;
    logic [PTR_W-1:0] LOAD_PTR;
    logic [PTR_W:0]   LOAD_COUNT;
    logic             MEM_FULL;

    modport master (
        output Read_Address, LOAD_MODE, LOAD_DATA, LOAD_BTN,
        input  Instruction, CPU_HOLD, LOAD_PTR, LOAD_COUNT, MEM_FULL
    );

    modport slave (
        input  Read_Address, LOAD_MODE, LOAD_DATA, LOAD_BTN,
        output Instruction, CPU_HOLD, LOAD_PTR, LOAD_COUNT, MEM_FULL
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory with a switch-panel program loader.
// state | meaning
// RUN   | processor runs, memory readable on Instruction
// LOAD  | processor held, each debounced button press stores one word
module instr_mem_loader #(
    parameter int DEPTH = 32,
    parameter int PTR_W = 5
) (
    input  logic                CLK,
    input  logic                RST,
    instr_mem_loader_if.slave   bus
);

    typedef enum logic {S_RUN = 1'b0, S_LOAD = 1'b1} state_t;

    state_t           state_q, state_d;
    logic             mode_s1_q, mode_s2_q;
    logic             btn_s1_q, btn_s2_q, btn_prev_q;
    logic [7:0]       data_s1_q, data_s2_q;
    logic             hold_q, hold_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             wp;
    logic             we;
    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       instr;

    // Raw switch and button inputs are asynchronous; data rides along so it
    // is aligned with the synchronized button.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_s1_q  <= 1'b0;
            mode_s2_q  <= 1'b0;
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            btn_prev_q <= 1'b0;
            data_s1_q  <= 8'h00;
            data_s2_q  <= 8'h00;
        end else begin
            mode_s1_q  <= bus.LOAD_MODE;
            mode_s2_q  <= mode_s1_q;
            btn_s1_q   <= bus.LOAD_BTN;
            btn_s2_q   <= btn_s1_q;
            btn_prev_q <= btn_s2_q;
            data_s1_q  <= bus.LOAD_DATA;
            data_s2_q  <= data_s1_q;
        end
    end

    assign wp = btn_s2_q & ~btn_prev_q;

    // Next state and load bookkeeping; leaving LOAD wins over a coincident write.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        full_d  = full_q;
        we      = 1'b0;
        case (state_q)
            S_RUN: begin
                if (mode_s2_q) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    full_d  = 1'b0;
                end
            end
            S_LOAD: begin
                if (!mode_s2_q) begin
                    state_d = S_RUN;
                end else if (wp && !full_q) begin
                    we     = 1'b1;
                    ptr_d  = ptr_q + PTR_W'(1);
                    cnt_d  = cnt_q + (PTR_W+1)'(1);
                    full_d = (cnt_q + (PTR_W+1)'(1)) == (PTR_W+1)'(DEPTH);
                end
            end
            default: state_d = S_RUN;
        endcase
        hold_d = (state_d == S_LOAD);
    end

    // State and registered status outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_RUN;
            hold_q  <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
        end
    end

    // Storage; reset clears the whole program so an aborted load leaves nothing behind.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
        end else if (we) begin
            mem_q[ptr_q] <= data_s2_q;
        end
    end

    // Fetch path: zero while loading or when the PC points past the memory.
    always_comb begin
        instr = 8'h00;
        if (state_q == S_RUN && 32'(bus.Read_Address) < DEPTH)
            instr = mem_q[bus.Read_Address[PTR_W-1:0]];
    end

    assign bus.Instruction = instr;
    assign bus.CPU_HOLD    = hold_q;
    assign bus.LOAD_PTR    = ptr_q;
    assign bus.LOAD_COUNT  = cnt_q;
    assign bus.MEM_FULL    = full_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader (DEPTH=32).
module tb_instr_mem_loader;

    logic CLK = 1'b0;
    logic RST;
    int   n_cmp  = 0;
    int   n_fail = 0;

    instr_mem_loader_if #(.PTR_W(5)) bus();

    instr_mem_loader #(.DEPTH(32), .PTR_W(5)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [7:0] d);
        bus.LOAD_DATA = d;
        bus.LOAD_BTN  = 1'b1;
        repeat (3) tick();
        bus.LOAD_BTN  = 1'b0;
        repeat (3) tick();
    endtask

    task automatic set_mode(input logic m);
        bus.LOAD_MODE = m;
        repeat (3) tick();
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
        bus.Read_Address = a;
        #1;
        chk(tag, {8'h00, bus.Instruction}, {8'h00, exp});
    endtask

    initial begin
        RST = 1'b1;
        bus.Read_Address = 8'h03;
        bus.LOAD_MODE    = 1'b0;
        bus.LOAD_DATA    = 8'h00;
        bus.LOAD_BTN     = 1'b0;
        repeat (2) tick();
        RST = 1'b0;
        tick();

        // reset state
        rd("rst_instr", 8'h03, 8'h00);
        chk("rst_hold",  16'(bus.CPU_HOLD),   16'h0);
        chk("rst_count", 16'(bus.LOAD_COUNT), 16'h0);
        chk("rst_ptr",   16'(bus.LOAD_PTR),   16'h0);
        chk("rst_full",  16'(bus.MEM_FULL),   16'h0);

        // mode entry goes through the synchronizer
        bus.LOAD_MODE = 1'b1;
        repeat (2) tick();
        chk("enter_hold_e2", 16'(bus.CPU_HOLD), 16'h0);
        tick();
        chk("enter_hold_e3", 16'(bus.CPU_HOLD), 16'h1);
        rd("load_instr_zero", 8'h00, 8'h00);

        // basic three-word load
        press(8'h56);
        press(8'h9B);
        press(8'hC1);
        chk("load3_hold",  16'(bus.CPU_HOLD),   16'h1);
        chk("load3_count", 16'(bus.LOAD_COUNT), 16'd3);
        chk("load3_ptr",   16'(bus.LOAD_PTR),   16'd3);
        set_mode(1'b0);
        chk("run_hold", 16'(bus.CPU_HOLD), 16'h0);
        rd("read0", 8'h00, 8'h56);
        rd("read1", 8'h01, 8'h9B);
        rd("read2", 8'h02, 8'hC1);

        // held button: exactly one write, on the third edge
        set_mode(1'b1);
        chk("reentry_count", 16'(bus.LOAD_COUNT), 16'h0);
        chk("reentry_ptr",   16'(bus.LOAD_PTR),   16'h0);
        bus.LOAD_DATA = 8'hA5;
        bus.LOAD_BTN  = 1'b1;
        tick();
        chk("hold_e1", 16'(bus.LOAD_COUNT), 16'd0);
        tick();
        chk("hold_e2", 16'(bus.LOAD_COUNT), 16'd0);
        tick();
        chk("hold_e3", 16'(bus.LOAD_COUNT), 16'd1);
        repeat (17) tick();
        chk("hold_20", 16'(bus.LOAD_COUNT), 16'd1);
        bus.LOAD_BTN = 1'b0;
        repeat (3) tick();
        set_mode(1'b0);
        rd("hold_mem0", 8'h00, 8'hA5);
        rd("hold_mem1", 8'h01, 8'h9B);

        // fill to DEPTH, then one more press that must be ignored
        set_mode(1'b1);
        for (int i = 0; i < 33; i++) begin
            press(8'(i));
            if (i == 30) chk("full_at31", 16'(bus.MEM_FULL), 16'h0);
            if (i == 31) chk("full_at32", 16'(bus.MEM_FULL), 16'h1);
        end
        chk("full_count", 16'(bus.LOAD_COUNT), 16'd32);
        chk("full_ptr",   16'(bus.LOAD_PTR),   16'd0);
        chk("full_flag",  16'(bus.MEM_FULL),   16'h1);
        set_mode(1'b0);
        rd("full_mem0",  8'h00, 8'h00);
        rd("full_mem2",  8'h02, 8'h02);
        rd("full_mem31", 8'h1F, 8'h1F);
        rd("addr_depth", 8'h20, 8'h00);

        // mode drop coinciding with the write pulse discards the write
        set_mode(1'b1);
        bus.LOAD_DATA = 8'h77;
        bus.LOAD_MODE = 1'b0;
        bus.LOAD_BTN  = 1'b1;
        repeat (3) tick();
        chk("race_hold",  16'(bus.CPU_HOLD),   16'h0);
        chk("race_count", 16'(bus.LOAD_COUNT), 16'h0);
        rd("race_mem0", 8'h00, 8'h00);
        rd("addr_40",   8'h40, 8'h00);
        bus.LOAD_BTN = 1'b0;
        repeat (3) tick();

        // reset mid-session
        set_mode(1'b1);
        press(8'h11);
        press(8'h22);
        chk("pre_rst_count", 16'(bus.LOAD_COUNT), 16'd2);
        RST = 1'b1;
        #1;
        chk("async_hold",  16'(bus.CPU_HOLD),   16'h0);
        chk("async_count", 16'(bus.LOAD_COUNT), 16'h0);
        chk("async_ptr",   16'(bus.LOAD_PTR),   16'h0);
        chk("async_full",  16'(bus.MEM_FULL),   16'h0);
        tick();
        RST = 1'b0;
        rd("rst_mem0",  8'h00, 8'h00);
        rd("rst_mem1",  8'h01, 8'h00);
        rd("rst_mem31", 8'h1F, 8'h00);
        repeat (2) tick();
        chk("rst_reentry_e2", 16'(bus.CPU_HOLD), 16'h0);
        tick();
        chk("rst_reentry_e3", 16'(bus.CPU_HOLD), 16'h1);
        chk("rst_reentry_count", 16'(bus.LOAD_COUNT), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
